// File: rtl/arbiter_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
package arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // Port 1 is treated as the previous owner after reset, so port 0 wins the first tie.
   localparam logic LAST_OWNER_RST = 1'b1;

endpackage

// File: rtl/mux.sv
// 2:1 WIDTH-bit selector feeding the shared datapath.
module mux #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] out
);

   // Pure combinational select; no latency relative to sel.
   assign out = sel ? in1 : in0;

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter for two level-held requesters with a bounded hold time.
module shared_bus_arbiter
   import arbiter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             preempt
);

   localparam int unsigned CNT_W = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             last_owner_q;
   logic             preempt_q, preempt_d;

   // Next-state selection: round-robin from IDLE, handoff on release, forced switch at the limit.
   always_comb begin
      state_d   = state_q;
      preempt_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               state_d = last_owner_q ? OWN0 : OWN1;
            end else if (req0) begin
               state_d = OWN0;
            end else if (req1) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            // A release in the limit cycle takes priority over the forced switch.
            if (!req0) begin
               state_d = req1 ? OWN1 : IDLE;
            end else if (req1 && (hold_cnt_q == HOLD_LAST)) begin
               state_d   = OWN1;
               preempt_d = 1'b1;
            end
         end
         OWN1: begin
            if (!req1) begin
               state_d = req0 ? OWN0 : IDLE;
            end else if (req0 && (hold_cnt_q == HOLD_LAST)) begin
               state_d   = OWN0;
               preempt_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, hold counter, round-robin pointer and preempt pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         hold_cnt_q   <= '0;
         last_owner_q <= LAST_OWNER_RST;
         preempt_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         preempt_q <= preempt_d;
         if ((state_d != state_q) || (state_q == IDLE)) begin
            hold_cnt_q <= '0;
         end else if (hold_cnt_q != HOLD_LAST) begin
            // Saturates so an uncontested owner keeps the bus indefinitely.
            hold_cnt_q <= hold_cnt_q + 1'b1;
         end
         if ((state_d == OWN0) && (state_q != OWN0)) begin
            last_owner_q <= 1'b0;
         end else if ((state_d == OWN1) && (state_q != OWN1)) begin
            last_owner_q <= 1'b1;
         end
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      gnt0      = (state_q == OWN0);
      gnt1      = (state_q == OWN1);
      sel       = (state_q == OWN1);
      out_valid = gnt0 | gnt1;
      preempt   = preempt_q;
   end

   mux #(
      .WIDTH(WIDTH)
   ) u_mux (
      .sel(sel),
      .in0(data0),
      .in1(data1),
      .out(out_data)
   );

endmodule

// File: doc/shared_bus_arbiter.md
# shared_bus_arbiter

- Two-requester round-robin arbiter that owns a WIDTH-bit shared datapath. It drives the select of an internal 2:1 `mux` and forwards the granted requester's data to a single consumer.
- Requests use a level-held req/gnt handshake. Ownership is bounded by a hold limit so neither requester can starve the other.
- The block sits between two producer units and the shared register/bus input.

## Interface
Parameters:
- WIDTH, 8, data width of each requester path and of the output.
- MAX_HOLD, 8, maximum consecutive owned cycles while the other side is waiting; legal range ≥ 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req0  in  1  requester 0 wants the bus; held high for the whole transfer.
- req1  in  1  requester 1, same rules as req0.
- data0  in  WIDTH  requester 0 data.
- data1  in  WIDTH  requester 1 data.
- gnt0  out  1  requester 0 owns the bus.
- gnt1  out  1  requester 1 owns the bus.
- sel  out  1  mux select: 1 when requester 1 owns, else 0.
- out_data  out  WIDTH  data0 when sel = 0, data1 when sel = 1.
- out_valid  out  1  gnt0 | gnt1.
- preempt  out  1  one-cycle pulse in the first cycle after a hold-limit forced switch.

## Operation
- State register uses three states: IDLE, OWN0, OWN1.
- Outputs are decoded from registered state only: gnt0 = (OWN0), gnt1 = (OWN1), sel = (OWN1), out_valid = gnt0 | gnt1.
- last_owner register:
  - Reset value is 1, so port 0 wins the first tie.
  - Updated to x on every entry into OWNx.
- IDLE transitions:
  - Both requests high: go to OWN of the port ≠ last_owner.
  - Only one request high: go to OWN of that port.
  - No request: stay in IDLE.
- OWNx transitions (y is the other port):
  - reqx low and reqy high: go to OWNy (back-to-back handoff, no idle bubble).
  - reqx low and reqy low: go to IDLE.
  - reqx high, reqy high, hold_cnt == MAX_HOLD-1: go to OWNy (forced switch); register preempt = 1.
  - Otherwise: stay in OWNx.
- hold_cnt:
  - Width is $clog2(MAX_HOLD).
  - Cleared on every state change and in IDLE.
  - Increments each cycle in OWNx while the state is kept.
  - Saturates at MAX_HOLD-1, so with no competitor ownership continues indefinitely.
- preempt is high only in the first cycle after a forced switch; it is low after a voluntary handoff.
- A requester that is preempted keeps its req high. It regains the bus by normal round-robin when the other side releases or times out.
- gnt0 and gnt1 are never high together; this is a bench assertion.

## Timing
- Grant latency: a req sampled high at rising edge k, with the bus free, gives gnt high after edge k. That is one cycle from req to gnt.
- Release latency: a req sampled low at edge k gives gnt low after edge k. The other grant, if pending, rises after the same edge.
- out_data is combinational from the data inputs through the mux: zero latency relative to sel.
- Reset values:
  - state = IDLE, hold_cnt = 0, last_owner = 1, preempt = 0.
  - Hence gnt0 = gnt1 = 0, sel = 0, out_valid = 0, out_data = data0.
- Reset asserted mid-ownership: all outputs drop immediately (asynchronous). The first grant after reset release follows the IDLE rules with last_owner = 1.
- A req dropping in the same cycle the hold limit is reached is handled as a release, not a preempt.

## Structure
- Package `arbiter_pkg`: state enum typedef (IDLE, OWN0, OWN1) and a localparam for the reset last_owner value.
- One sub-module: `mux`, a 2:1 WIDTH-bit selector with sel, in0 = data0, in1 = data1, out = out_data. It is instantiated once.
- FSM and counter stay in one always_ff with asynchronous reset, plus an always_comb block for next state.

## Test plan
- Reset: hold rst_n low with req0 = req1 = 1 → gnt0 = gnt1 = 0, sel = 0, out_valid = 0. Release rst_n → gnt0 = 1 one cycle later.
- Single requester: req1 high for 20 cycles, data1 = 8'hA5, MAX_HOLD = 8 → gnt1 is held all 20 cycles, out_data = 8'hA5, preempt never pulses.
- Tie-break: req0 and req1 rise together from IDLE after reset → OWN0. Drop req0 → gnt1 the next cycle with no idle gap. Raise req0 again later while req1 releases → gnt0.
- Hold limit: req0 and req1 both held high, MAX_HOLD = 8 → gnt alternates every 8 cycles, with preempt = 1 in the first cycle of each new owner.
- Release at limit: req0 drops exactly in the cycle hold_cnt = 7 while req1 is high → gnt1 next cycle, preempt = 0.
- Asynchronous reset mid-transfer: assert rst_n low between edges during OWN1 → gnt1 and sel fall without waiting for a clock edge. After release, the first tie goes to port 0.
